// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD game-clock countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    // Top-level control states of the countdown.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    // One BCD decade.
    typedef logic [3:0] bcd_t;

    // Largest legal value of the seconds-tens decade (x0..x5).
    localparam int SEC_TENS_MAX = 5;
    // Largest legal value of a plain decimal decade.
    localparam int BCD_MAX      = 9;

    // Saturate an out-of-range preset to the decade's largest legal value.
    function automatic bcd_t clampBcd(input bcd_t val, input bcd_t maxVal);
        return (val > maxVal) ? maxVal : val;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of a down counter with clamped parallel load and borrow out.
// Latency: load/decrement visible one clk after the command cycle; borrowOut is combinational.
// Backpressure: none; load wins over dec, dec is applied whenever asserted.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic [W-1:0] digit,
    output logic         borrowOut
);

    localparam logic [W-1:0] MAX_VAL = W'(MAX);

    logic [W-1:0] loadClamped;

    // Presets above the decade's range saturate instead of wrapping.
    always_comb begin
        loadClamped = W'(clampBcd(bcd_t'(loadVal), bcd_t'(MAX)));
    end

    // Decade register: load has priority, decrement wraps 0 -> MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= loadClamped;
        end else if (dec) begin
            digit <= (digit == '0) ? MAX_VAL : (digit - W'(1));
        end
    end

    // A decrement of a zero digit asks the next decade up for a borrow.
    assign borrowOut = dec && (digit == '0);

endmodule

// File: rtl/tick_countdown_timer.sv
// M:SS BCD game-clock countdown paced by the prescaler's tickEn pulse, with load/start/pause.
// Latency: commands and second decrements take effect on the edge after their cycle.
// Backpressure: none; load > (start xor pause) > tickEn, a losing tickEn is dropped.
module tick_countdown_timer
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int WARN_SEC      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tickEn,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] loadMin,
    input  logic [2:0] loadSecT,
    input  logic [3:0] loadSecU,
    output logic [3:0] minDigit,
    output logic [2:0] secTens,
    output logic [3:0] secUnits,
    output logic       running,
    output logic       expired,
    output logic       expiredPulse,
    output logic       warning
);

    // A single-tick second still needs a one-bit counter register.
    localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

    timer_state_t     state;
    timer_state_t     nextState;
    logic [SUB_W-1:0] subCnt;

    logic startCmd;
    logic pauseCmd;
    logic timeNonZero;
    logic runTick;
    logic secondDone;
    logic decUnits;
    logic unitsBorrow;
    logic tensBorrow;
    logic minBorrow;
    logic lastSecond;
    logic reachZero;
    logic [6:0] secTotal;

    // Command decode: simultaneous start and pause cancel each other.
    always_comb begin
        startCmd    = start && !pause;
        pauseCmd    = pause && !start;
        timeNonZero = (minDigit != 4'd0) || (secTens != 3'd0) || (secUnits != 4'd0);
        // A tick only counts in RUN and only when no higher-priority command owns the cycle.
        runTick     = (state == RUN) && tickEn && !load && !pauseCmd;
        secondDone  = runTick && (subCnt == SUB_LAST);
        // The zero guard keeps the clock from ever wrapping below 0:00.
        decUnits    = secondDone && timeNonZero;
        lastSecond  = decUnits && (minDigit == 4'd0) && (secTens == 3'd0)
                      && (secUnits == 4'd1);
        // A minute borrow can only mean an underflow; treat it as expiry too.
        reachZero   = lastSecond || minBorrow;
    end

    // Sub-second tick counter, cleared by load and held outside RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            subCnt <= '0;
        end else if (load) begin
            subCnt <= '0;
        end else if (runTick) begin
            subCnt <= (subCnt == SUB_LAST) ? '0 : (subCnt + SUB_W'(1));
        end
    end

    bcd_down_digit #(
        .MAX (BCD_MAX),
        .W   (4)
    ) uUnits (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .loadVal   (loadSecU),
        .dec       (decUnits),
        .digit     (secUnits),
        .borrowOut (unitsBorrow)
    );

    bcd_down_digit #(
        .MAX (SEC_TENS_MAX),
        .W   (3)
    ) uTens (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .loadVal   (loadSecT),
        .dec       (unitsBorrow),
        .digit     (secTens),
        .borrowOut (tensBorrow)
    );

    bcd_down_digit #(
        .MAX (BCD_MAX),
        .W   (4)
    ) uMin (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .loadVal   (loadMin),
        .dec       (tensBorrow),
        .digit     (minDigit),
        .borrowOut (minBorrow)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: load from anywhere returns to IDLE; EXPIRED only leaves on load.
    always_comb begin
        nextState = state;
        if (load) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (startCmd && timeNonZero) begin
                        nextState = RUN;
                    end
                end
                RUN: begin
                    if (pauseCmd) begin
                        nextState = PAUSED;
                    end else if (reachZero) begin
                        nextState = EXPIRED;
                    end
                end
                EXPIRED: nextState = EXPIRED;
                default: nextState = IDLE;
            endcase
        end
    end

    // Entry-to-EXPIRED strobe, registered so it lines up with expired rising.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expiredPulse <= 1'b0;
        end else begin
            expiredPulse <= (state == RUN) && (nextState == EXPIRED);
        end
    end

    // Status outputs decoded from the state and digit registers.
    always_comb begin
        // Warning thresholds never exceed a minute, so only 0:SS can qualify.
        secTotal = (7'(secTens) * 7'd10) + 7'(secUnits);
        running  = (state == RUN);
        expired  = (state == EXPIRED);
        warning  = (state == RUN) && (minDigit == 4'd0) && (secTotal < 7'(WARN_SEC));
    end

endmodule

// File: tb/tb_tick_countdown_timer.sv
module tb_tick_countdown_timer;

    logic       clk;
    logic       reset;
    logic       tickEn;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] loadMin;
    logic [2:0] loadSecT;
    logic [3:0] loadSecU;
    logic [3:0] minDigit;
    logic [2:0] secTens;
    logic [3:0] secUnits;
    logic       running;
    logic       expired;
    logic       expiredPulse;
    logic       warning;

    int total;
    int bad;

    tick_countdown_timer #(
        .TICKS_PER_SEC (4),
        .WARN_SEC      (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tickEn       (tickEn),
        .load         (load),
        .start        (start),
        .pause        (pause),
        .loadMin      (loadMin),
        .loadSecT     (loadSecT),
        .loadSecU     (loadSecU),
        .minDigit     (minDigit),
        .secTens      (secTens),
        .secUnits     (secUnits),
        .running      (running),
        .expired      (expired),
        .expiredPulse (expiredPulse),
        .warning      (warning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic       st;
        logic       ps;
        logic       tk;
        logic [3:0] m;
        logic [2:0] t;
        logic [3:0] u;
        logic [3:0] eM;
        logic [2:0] eT;
        logic [3:0] eU;
        logic       eRun;
        logic       eExp;
        logic       ePulse;
        logic       eWarn;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [3:0] m, input logic [2:0] t,
                         input logic [3:0] u, input logic run, input logic exp,
                         input logic pulse, input logic warn);
        total++;
        if ({minDigit, secTens, secUnits, running, expired, expiredPulse, warning} !==
            {m, t, u, run, exp, pulse, warn}) begin
            bad++;
            $display("FAIL %s: got %0d:%0d%0d run=%b exp=%b pulse=%b warn=%b, want %0d:%0d%0d run=%b exp=%b pulse=%b warn=%b",
                     name, minDigit, secTens, secUnits, running, expired, expiredPulse, warning,
                     m, t, u, run, exp, pulse, warn);
        end
    endtask

    // Drive one cycle of commands, then sample just after the edge.
    task automatic cyc(input logic ld, input logic st, input logic ps, input logic tk,
                       input logic [3:0] m, input logic [2:0] t, input logic [3:0] u);
        load     = ld;
        start    = st;
        pause    = ps;
        tickEn   = tk;
        loadMin  = m;
        loadSecT = t;
        loadSecU = u;
        @(posedge clk);
        #1;
        load   = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        tickEn = 1'b0;
    endtask

    task automatic doLoad(input logic [3:0] m, input logic [2:0] t, input logic [3:0] u);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, m, t, u);
    endtask

    task automatic doStart();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 4'd0);
    endtask

    task automatic doPause();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 4'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 4'd0);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        tickEn   = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        loadMin  = 4'd0;
        loadSecT = 3'd0;
        loadSecU = 4'd0;

        //                ld    st    ps    tk    m      t     u      eM    eT    eU    run   exp   pls   warn
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  3'd7, 4'd12, 4'd9, 3'd5, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd9,  3'd7, 4'd12, 4'd9, 3'd5, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd9, 3'd5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  3'd0, 4'd0,  4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  3'd0, 4'd0,  4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  3'd0, 4'd0,  4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 3'd3, 4'd4,  4'd9, 3'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Clamp / priority / pause vectors
        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].ld, vecs[i].st, vecs[i].ps, vecs[i].tk, vecs[i].m, vecs[i].t, vecs[i].u);
            check($sformatf("vec%0d", i), vecs[i].eM, vecs[i].eT, vecs[i].eU,
                  vecs[i].eRun, vecs[i].eExp, vecs[i].ePulse, vecs[i].eWarn);
        end

        // Whole-second pacing: 4 ticks per second
        doLoad(4'd1, 3'd0, 4'd5);
        doStart();
        check("sec_start", 4'd1, 3'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        check("sec_4ticks", 4'd1, 3'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check("sec_3more", 4'd1, 3'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Borrow chain across the minute and warning threshold
        doLoad(4'd1, 3'd0, 4'd0);
        doStart();
        ticks(4);
        check("borrow_059", 4'd0, 3'd5, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(36);
        check("borrow_050", 4'd0, 3'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        check("borrow_049", 4'd0, 3'd4, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        doLoad(4'd0, 3'd1, 4'd1);
        doStart();
        ticks(4);
        check("warn_010", 4'd0, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        check("warn_009", 4'd0, 3'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        doPause();
        check("warn_paused", 4'd0, 3'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);

        // Expiry
        doLoad(4'd0, 3'd0, 4'd2);
        doStart();
        check("exp_start", 4'd0, 3'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(7);
        check("exp_001", 4'd0, 3'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(1);
        check("exp_entry", 4'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(1);
        check("exp_pulse_end", 4'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        doStart();
        check("exp_hold", 4'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        doLoad(4'd0, 3'd0, 4'd5);
        check("exp_leave", 4'd0, 3'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pause retains the sub-second count
        doLoad(4'd0, 3'd0, 4'd3);
        doStart();
        ticks(2);
        doPause();
        ticks(10);
        check("pause_hold", 4'd0, 3'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        doStart();
        check("pause_resume", 4'd0, 3'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        ticks(2);
        check("pause_sub_kept", 4'd0, 3'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 4'd0);
        check("start_pause_same", 4'd0, 3'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset mid-run
        doLoad(4'd1, 3'd2, 4'd3);
        doStart();
        ticks(2);
        reset = 1'b1;
        #1;
        check("reset_async", 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_midrun", 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        doStart();
        check("reset_idle", 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
